// File: rtl/imul_ctrl_pkg.sv
// Shared state encoding and datapath mux-select constants for the iterative
// shift-add multiplier control unit.
package imul_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic A_SEL_LD     = 1'b1;
  localparam logic A_SEL_SH     = 1'b0;
  localparam logic B_SEL_LD     = 1'b1;
  localparam logic B_SEL_SH     = 1'b0;
  localparam logic RES_SEL_ZERO = 1'b1;
  localparam logic RES_SEL_ADD  = 1'b0;
  localparam logic ADD_SEL_SUM  = 1'b0;
  localparam logic ADD_SEL_PASS = 1'b1;

endpackage

// File: rtl/imul_iter_counter.sv
// Iteration counter for the shift-add multiplier: clear has priority over
// increment, and the count saturates at p_nbits-1 (flagged by last).
module imul_iter_counter #(
  parameter int p_nbits = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic last
);

  localparam int p_cnt_bits = (p_nbits > 1) ? $clog2(p_nbits) : 1;

  logic [p_cnt_bits-1:0] count_q;
  logic [p_cnt_bits-1:0] count_d;

  assign last = (count_q == p_cnt_bits'(p_nbits - 1));

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !last) begin
      count_d = count_q + p_cnt_bits'(1);
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/imul_base_ctrl.sv
// Control unit for the iterative shift-add multiplier datapath (IDLE/CALC/DONE).
// Optional early exit on b==0 is enabled by defining IMUL_EARLY_EXIT_EN.
module imul_base_ctrl
  import imul_ctrl_pkg::*;
#(
  parameter int p_nbits = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic req_val,
  output logic req_rdy,
  output logic resp_val,
  input  logic resp_rdy,
  output logic a_mux_sel,
  output logic b_mux_sel,
  output logic result_mux_sel,
  output logic add_mux_sel,
  output logic result_en,
  input  logic b_lsb,
  input  logic b_zero,
  output logic busy
);

  state_e state_q;
  state_e state_d;
  logic   cnt_clr;
  logic   cnt_inc;
  logic   cnt_last;

`ifndef IMUL_EARLY_EXIT_EN
  logic unused_b_zero;
  assign unused_b_zero = b_zero;
`endif

  imul_iter_counter #(
    .p_nbits(p_nbits)
  ) u_iter_counter (
    .clk  (clk),
    .reset(reset),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .last (cnt_last)
  );

  // NOTE: every output gets its IDLE value before the case statement, so no
  // path through the block leaves a signal unassigned (no latches).
  always_comb begin
    state_d        = state_q;
    cnt_clr        = 1'b0;
    cnt_inc        = 1'b0;
    req_rdy        = 1'b1;
    resp_val       = 1'b0;
    busy           = 1'b0;
    a_mux_sel      = A_SEL_LD;
    b_mux_sel      = B_SEL_LD;
    result_mux_sel = RES_SEL_ZERO;
    add_mux_sel    = ADD_SEL_PASS;
    result_en      = 1'b1;

    case (state_q)
      IDLE: begin
        if (req_val) begin
          state_d = CALC;
          cnt_clr = 1'b1;
        end
      end

      CALC: begin
        req_rdy        = 1'b0;
        busy           = 1'b1;
        a_mux_sel      = A_SEL_SH;
        b_mux_sel      = B_SEL_SH;
        result_mux_sel = RES_SEL_ADD;
        add_mux_sel    = b_lsb ? ADD_SEL_SUM : ADD_SEL_PASS;
        cnt_inc        = 1'b1;
        if (cnt_last) begin
          state_d = DONE;
          cnt_clr = 1'b1;
        end
`ifdef IMUL_EARLY_EXIT_EN
        // Once b has shifted to zero the remaining iterations add nothing.
        if (b_zero) begin
          state_d = DONE;
          cnt_clr = 1'b1;
        end
`endif
      end

      DONE: begin
        req_rdy        = 1'b0;
        resp_val       = 1'b1;
        busy           = 1'b1;
        a_mux_sel      = A_SEL_SH;
        b_mux_sel      = B_SEL_SH;
        result_mux_sel = RES_SEL_ADD;
        add_mux_sel    = ADD_SEL_PASS;
        result_en      = 1'b0;
        if (resp_rdy) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_imul_base_ctrl.sv
// Self-checking bench for imul_base_ctrl: a simple shift-add datapath is
// attached and results/latencies are compared against plain arithmetic.
module tb_imul_base_ctrl;

  localparam int P_NBITS = 32;

  logic clk = 1'b0;
  logic reset;
  logic req_val;
  logic req_rdy;
  logic resp_val;
  logic resp_rdy;
  logic a_mux_sel;
  logic b_mux_sel;
  logic result_mux_sel;
  logic add_mux_sel;
  logic result_en;
  logic b_lsb;
  logic b_zero;
  logic busy;

  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [31:0] dp_a  = '0;
  logic [31:0] dp_b  = '0;
  logic [31:0] dp_res = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imul_base_ctrl #(.p_nbits(P_NBITS)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_val       (req_val),
    .req_rdy       (req_rdy),
    .resp_val      (resp_val),
    .resp_rdy      (resp_rdy),
    .a_mux_sel     (a_mux_sel),
    .b_mux_sel     (b_mux_sel),
    .result_mux_sel(result_mux_sel),
    .add_mux_sel   (add_mux_sel),
    .result_en     (result_en),
    .b_lsb         (b_lsb),
    .b_zero        (b_zero),
    .busy          (busy)
  );

  // Datapath the controller steers.
  assign b_lsb  = dp_b[0];
  assign b_zero = (dp_b == '0);

  always_ff @(posedge clk) begin
    dp_a <= a_mux_sel ? req_a : (dp_a << 1);
    dp_b <= b_mux_sel ? req_b : (dp_b >> 1);
    if (result_en) begin
      dp_res <= result_mux_sel ? '0 : (add_mux_sel ? dp_res : dp_res + dp_a);
    end
  end

  // Packed view: {req_rdy, resp_val, busy, result_en, a_sel, b_sel, add_sel}
  localparam logic [6:0] OUTS_IDLE = 7'b1001111;
  localparam logic [6:0] OUTS_DONE = 7'b0110001;

  function automatic logic [6:0] outs();
    return {req_rdy, resp_val, busy, result_en, a_mux_sel, b_mux_sel, add_mux_sel};
  endfunction

  function automatic logic [6:0] outs_calc(input logic add_sel);
    return {6'b001100, add_sel};
  endfunction

  function automatic int exp_latency(input logic [31:0] b);
    int n;
`ifdef IMUL_EARLY_EXIT_EN
    int bl;
    bl = 0;
    for (int i = 0; i < 32; i++) if (b[i]) bl = i + 1;
    n = (bl + 1 > P_NBITS) ? P_NBITS : bl + 1;
`else
    n = P_NBITS;
`endif
    return 1 + n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a request and follow it through CALC until resp_val rises.
  task automatic issue_op(input logic [31:0] a, input logic [31:0] b, input bit keep_req);
    int lat;
    logic exp_add;
    lat = 0;
    while (req_rdy !== 1'b1 && lat < 200) begin
      step();
      lat++;
    end
    check("req_rdy_wait", req_rdy, 1);
    req_a   = a;
    req_b   = b;
    req_val = 1'b1;
    #1;
    check("idle_outs", outs(), OUTS_IDLE);
    step();
    if (!keep_req) req_val = 1'b0;
    lat = 1;
    while (resp_val !== 1'b1 && lat < 100) begin
      exp_add = (lat - 1 < 32) ? ~b[lat-1] : 1'b1;
      check("calc_outs", outs(), outs_calc(exp_add));
      check("calc_res_sel", result_mux_sel, 0);
      step();
      lat++;
    end
    check("latency", lat, exp_latency(b));
  endtask

  // Hold the response for `hold` cycles, then complete the handshake.
  task automatic finish_op(input logic [31:0] exp, input int hold);
    resp_rdy = 1'b0;
    for (int i = 0; i < hold; i++) begin
      check("done_outs_hold", outs(), OUTS_DONE);
      check("resp_msg_hold", dp_res, exp);
      step();
    end
    resp_rdy = 1'b1;
    #1;
    check("done_outs", outs(), OUTS_DONE);
    check("resp_msg", dp_res, exp);
    step();
    resp_rdy = 1'b0;
    check("idle_after_resp", outs(), OUTS_IDLE);
    check("idle_res_sel", result_mux_sel, 1);
  endtask

  task automatic check_reset_outs(input string name);
    check(name, outs(), OUTS_IDLE);
    check({name, "_res_sel"}, result_mux_sel, 1);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          hold;
    bit          keep_req;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{32'd3,        32'd5,        32'd15,         0, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE,   0, 1'b1};
    vecs[2] = '{32'h00001234, 32'h00000010, 32'h00012340,   5, 1'b0};
    vecs[3] = '{32'd9,        32'd1,        32'd9,          0, 1'b0};
    vecs[4] = '{32'd0,        32'd0,        32'd0,          1, 1'b0};
    vecs[5] = '{32'h80000001, 32'hFFFFFFFF, 32'h7FFFFFFF,   2, 1'b0};
    vecs[6] = '{32'd12345,    32'h80000000, 32'h80000000,   0, 1'b0};

    reset    = 1'b0;
    req_val  = 1'b0;
    resp_rdy = 1'b0;
    #2;
    check_reset_outs("reset_outs");
    step();
    step();
    reset = 1'b1;
    step();
    check_reset_outs("after_release");

    // Directed vectors.
    for (int i = 0; i < 7; i++) begin
      issue_op(vecs[i].a, vecs[i].b, vecs[i].keep_req);
      if (vecs[i].keep_req) check("req_blocked_in_done", req_rdy, 0);
      finish_op(vecs[i].exp, vecs[i].hold);
    end

    // Reset pulse at CALC iteration 10, then a fresh op at full latency.
    req_a   = 32'd123;
    req_b   = 32'hFFFF0000;
    req_val = 1'b1;
    step();
    req_val = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("busy_before_abort", busy, 1);
    #3 reset = 1'b0;
    #1 check_reset_outs("abort_calc");
    step();
    reset = 1'b1;
    step();
    check_reset_outs("abort_calc_hold");
    issue_op(32'd7, 32'd6, 1'b0);
    finish_op(32'd42, 0);

    // Reset while the response is pending drops resp_val at once.
    issue_op(32'd11, 32'd13, 1'b0);
    check("resp_val_pending", resp_val, 1);
    #3 reset = 1'b0;
    #1 check_reset_outs("abort_done");
    step();
    reset = 1'b1;
    step();
    issue_op(32'd21, 32'd2, 1'b0);
    finish_op(32'd42, 1);

    // Randomised operands against plain multiplication.
    for (int i = 0; i < 20; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic [31:0] rexp;
      ra   = $urandom;
      rb   = $urandom >> $urandom_range(0, 31);
      rexp = ra * rb;
      issue_op(ra, rb, 1'b0);
      finish_op(rexp, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
